// File: rtl/tl_fragment_ack_collector.sv
// D-channel fragment ack collector: forwards data beats with original size/source
// restored, absorbs intermediate AccessAcks. Optional FRAG_COLLECT_SRC_CHECK_EN.
module tl_fragment_ack_collector (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_expect_valid,
    output logic        io_expect_ready,
    input  logic [3:0]  io_expect_count,
    input  logic [2:0]  io_expect_size,
    input  logic [5:0]  io_expect_source,

    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [2:0]  io_in_bits_opcode,
    input  logic [1:0]  io_in_bits_param,
    input  logic [2:0]  io_in_bits_size,
    input  logic [5:0]  io_in_bits_source,
    input  logic        io_in_bits_sink,
    input  logic        io_in_bits_denied,
    input  logic [63:0] io_in_bits_data,
    input  logic        io_in_bits_corrupt,

    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [2:0]  io_out_bits_opcode,
    output logic [1:0]  io_out_bits_param,
    output logic [2:0]  io_out_bits_size,
    output logic [5:0]  io_out_bits_source,
    output logic        io_out_bits_sink,
    output logic        io_out_bits_denied,
    output logic [63:0] io_out_bits_data,
    output logic        io_out_bits_corrupt,

    output logic        io_busy,
    output logic        io_error
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned SRC_W  = 6;
    localparam logic [2:0]  OP_ACCESS_ACK = 3'd0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [SIZE_W-1:0]   saved_size_q, saved_size_d;
    logic [SRC_W-1:0]    saved_source_q, saved_source_d;
    logic                denied_acc_q, denied_acc_d;
    logic                last_c, suppress_c, fire_c;
`ifdef FRAG_COLLECT_SRC_CHECK_EN
    logic                error_q, error_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            saved_size_q   <= '0;
            saved_source_q <= '0;
            denied_acc_q   <= 1'b0;
`ifdef FRAG_COLLECT_SRC_CHECK_EN
            error_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            saved_size_q   <= saved_size_d;
            saved_source_q <= saved_source_d;
            denied_acc_q   <= denied_acc_d;
`ifdef FRAG_COLLECT_SRC_CHECK_EN
            error_q        <= error_d;
`endif
        end
    end

    // Next state plus handshake decode; suppressed acks ignore upstream backpressure.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        saved_size_d    = saved_size_q;
        saved_source_d  = saved_source_q;
        denied_acc_d    = denied_acc_q;
        last_c          = 1'b0;
        suppress_c      = 1'b0;
        fire_c          = 1'b0;
        io_expect_ready = 1'b0;
        io_in_ready     = 1'b0;
        io_out_valid    = 1'b0;
        io_busy         = 1'b0;
`ifdef FRAG_COLLECT_SRC_CHECK_EN
        error_d         = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                io_expect_ready = 1'b1;
                if (io_expect_valid) begin
                    state_d        = ST_COLLECT;
                    remaining_d    = io_expect_count;
                    saved_size_d   = io_expect_size;
                    saved_source_d = io_expect_source;
                    denied_acc_d   = 1'b0;
                end
            end
            ST_COLLECT: begin
                io_busy    = 1'b1;
                last_c     = (remaining_q == '0);
                suppress_c = (io_in_bits_opcode == OP_ACCESS_ACK) && !last_c;
                if (suppress_c) begin
                    io_in_ready = 1'b1;
                end else begin
                    io_in_ready  = io_out_ready;
                    io_out_valid = io_in_valid;
                end
                fire_c = io_in_valid && io_in_ready;
                if (fire_c) begin
                    if (last_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                    if (suppress_c) begin
                        denied_acc_d = denied_acc_q | io_in_bits_denied;
                    end
`ifdef FRAG_COLLECT_SRC_CHECK_EN
                    error_d = (io_in_bits_source != saved_source_q);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign io_out_bits_opcode  = io_in_bits_opcode;
    assign io_out_bits_param   = io_in_bits_param;
    assign io_out_bits_size    = saved_size_q;
    assign io_out_bits_source  = saved_source_q;
    assign io_out_bits_sink    = io_in_bits_sink;
    assign io_out_bits_denied  = denied_acc_q | io_in_bits_denied;
    assign io_out_bits_data    = io_in_bits_data;
    assign io_out_bits_corrupt = io_in_bits_corrupt;

`ifdef FRAG_COLLECT_SRC_CHECK_EN
    assign io_error = error_q;
`else
    assign io_error = 1'b0;
`endif

    // Downstream size/source are replaced by the saved originals.
    logic unused_c;
    assign unused_c = ^{io_in_bits_size, io_in_bits_source};

endmodule

// File: tb/tb_tl_fragment_ack_collector.sv
// Scoreboard bench for tl_fragment_ack_collector: directed test-plan cases plus
// randomized requests against a per-request behavioural model.
module tb_tl_fragment_ack_collector;

`ifdef FRAG_COLLECT_SRC_CHECK_EN
    localparam bit SRC_CHK = 1'b1;
`else
    localparam bit SRC_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_expect_valid, io_expect_ready;
    logic [3:0]  io_expect_count;
    logic [2:0]  io_expect_size;
    logic [5:0]  io_expect_source;
    logic        io_in_valid, io_in_ready;
    logic [2:0]  io_in_bits_opcode;
    logic [1:0]  io_in_bits_param;
    logic [2:0]  io_in_bits_size;
    logic [5:0]  io_in_bits_source;
    logic        io_in_bits_sink, io_in_bits_denied, io_in_bits_corrupt;
    logic [63:0] io_in_bits_data;
    logic        io_out_valid, io_out_ready;
    logic [2:0]  io_out_bits_opcode;
    logic [1:0]  io_out_bits_param;
    logic [2:0]  io_out_bits_size;
    logic [5:0]  io_out_bits_source;
    logic        io_out_bits_sink, io_out_bits_denied, io_out_bits_corrupt;
    logic [63:0] io_out_bits_data;
    logic        io_busy, io_error;

    always #5 clk = ~clk;

    tl_fragment_ack_collector dut (
        .clock(clk), .reset(rst_n),
        .io_expect_valid(io_expect_valid), .io_expect_ready(io_expect_ready),
        .io_expect_count(io_expect_count), .io_expect_size(io_expect_size),
        .io_expect_source(io_expect_source),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_bits_opcode(io_in_bits_opcode), .io_in_bits_param(io_in_bits_param),
        .io_in_bits_size(io_in_bits_size), .io_in_bits_source(io_in_bits_source),
        .io_in_bits_sink(io_in_bits_sink), .io_in_bits_denied(io_in_bits_denied),
        .io_in_bits_data(io_in_bits_data), .io_in_bits_corrupt(io_in_bits_corrupt),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_bits_opcode(io_out_bits_opcode), .io_out_bits_param(io_out_bits_param),
        .io_out_bits_size(io_out_bits_size), .io_out_bits_source(io_out_bits_source),
        .io_out_bits_sink(io_out_bits_sink), .io_out_bits_denied(io_out_bits_denied),
        .io_out_bits_data(io_out_bits_data), .io_out_bits_corrupt(io_out_bits_corrupt),
        .io_busy(io_busy), .io_error(io_error)
    );

    typedef logic [80:0] beat_t;   // {op,param,size,src,sink,denied,data,corrupt}
    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    ready_mode = 2;         // 0 random, 1 low, 2 high
    logic  err_exp = 1'b0;

    // Request model: what the initiator must see for the current descriptor.
    logic [3:0] m_rem;
    logic [2:0] m_size;
    logic [5:0] m_src;
    logic       m_acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream ready generator.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       io_out_ready = ($urandom_range(3) != 0);
            1:       io_out_ready = 1'b0;
            default: io_out_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every upstream handshake and tracks io_error.
    always @(negedge clk) begin
        beat_t got, e;
        if (!rst_n) begin
            err_exp = 1'b0;
        end else begin
            check("io_error", io_error, err_exp);
            err_exp = 1'b0;
            if (io_in_valid && io_in_ready)
                err_exp = SRC_CHK && (io_in_bits_source != m_src);
            if (io_out_valid && io_out_ready) begin
                got = {io_out_bits_opcode, io_out_bits_param, io_out_bits_size,
                       io_out_bits_source, io_out_bits_sink, io_out_bits_denied,
                       io_out_bits_data, io_out_bits_corrupt};
                if (exp_q.size() == 0) begin
                    check("out_unexpected", got, 128'h0);
                    if (got == '0) begin
                        bad++;
                        $display("FAIL out_unexpected: got beat %0h expected none", got);
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", got, e);
                end
            end
        end
    end

    // Starts and ends at posedge+1.
    task automatic send_desc(input logic [3:0] cnt, input logic [2:0] sz, input logic [5:0] src);
        int n = 0;
        io_expect_valid  = 1'b1;
        io_expect_count  = cnt;
        io_expect_size   = sz;
        io_expect_source = src;
        m_rem = cnt; m_size = sz; m_src = src; m_acc = 1'b0;
        @(negedge clk);
        while (!io_expect_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("desc_accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        io_expect_valid = 1'b0;
        check("busy_after_desc", io_busy, 1'b1);
    endtask

    task automatic send_beat(input logic [2:0] op, input logic den, input logic [63:0] data,
                             input logic [5:0] src, input int stall);
        logic last, supp;
        logic [1:0] prm;
        logic snk, cor;
        int n = 0;
        prm  = 2'($urandom_range(3));
        snk  = 1'($urandom_range(1));
        cor  = 1'($urandom_range(1));
        last = (m_rem == 0);
        supp = (op == 3'd0) && !last;
        if (supp) m_acc = m_acc | den;
        else exp_q.push_back({op, prm, m_size, m_src, snk, m_acc | den, data, cor});
        io_in_valid = 1'b1;
        io_in_bits_opcode = op;   io_in_bits_param  = prm;
        io_in_bits_size   = 3'($urandom_range(7));
        io_in_bits_source = src;  io_in_bits_sink   = snk;
        io_in_bits_denied = den;  io_in_bits_data   = data;
        io_in_bits_corrupt = cor;
        forever begin
            @(negedge clk);
            if (supp) begin
                check("supp_in_ready", io_in_ready, 1'b1);
                check("supp_out_valid", io_out_valid, 1'b0);
            end else begin
                check("fwd_in_ready", io_in_ready, io_out_ready);
                check("fwd_out_valid", io_out_valid, 1'b1);
            end
            if (io_in_ready) break;
            n++;
            if (n == stall) ready_mode = 2;
            if (n >= 50) break;
        end
        check("beat_timeout", 32'(n < 50), 32'd1);
        if (stall > 0) check("stall_cycles", 32'(n), 32'(stall));
        @(posedge clk); #1;
        io_in_valid = 1'b0;
        if (last) begin
            check("busy_after_last", io_busy, 1'b0);
            check("expect_ready_after_last", io_expect_ready, 1'b1);
        end else begin
            m_rem = m_rem - 4'd1;
        end
    endtask

    initial begin
        logic [5:0] s;
        rst_n = 1'b0;
        io_expect_valid = 1'b0; io_expect_count = '0; io_expect_size = '0; io_expect_source = '0;
        io_in_valid = 1'b0; io_in_bits_opcode = '0; io_in_bits_param = '0; io_in_bits_size = '0;
        io_in_bits_source = '0; io_in_bits_sink = 1'b0; io_in_bits_denied = 1'b0;
        io_in_bits_data = '0; io_in_bits_corrupt = 1'b0; io_out_ready = 1'b1;
        m_rem = '0; m_size = '0; m_src = '0; m_acc = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_expect_ready", io_expect_ready, 1'b1);
        check("rst_in_ready", io_in_ready, 1'b0);
        check("rst_out_valid", io_out_valid, 1'b0);
        check("rst_busy", io_busy, 1'b0);
        check("rst_error", io_error, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Four acks, only the last is forwarded.
        send_desc(4'd3, 3'd6, 6'h15);
        for (int i = 0; i < 4; i++) send_beat(3'd0, 1'b0, 64'($urandom), 6'h15, 0);

        // Two data beats pass through with size restored.
        send_desc(4'd1, 3'd5, 6'h22);
        send_beat(3'd1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 6'h22, 0);
        send_beat(3'd1, 1'b0, 64'h5A5A_5A5A_5A5A_5A5A, 6'h22, 0);

        // Denied accumulation, then cleared for the next request.
        send_desc(4'd2, 3'd3, 6'h07);
        send_beat(3'd0, 1'b0, '0, 6'h07, 0);
        send_beat(3'd0, 1'b1, '0, 6'h07, 0);
        send_beat(3'd0, 1'b0, '0, 6'h07, 0);
        send_desc(4'd2, 3'd3, 6'h07);
        for (int i = 0; i < 3; i++) send_beat(3'd0, 1'b0, '0, 6'h07, 0);

        // Backpressure: suppressed beat consumed, forwarded beat held 3 cycles.
        ready_mode = 1;
        send_desc(4'd1, 3'd2, 6'h3c);
        send_beat(3'd0, 1'b0, '0, 6'h3c, 0);
        send_beat(3'd0, 1'b0, 64'hDEAD_BEEF_0123_4567, 6'h3c, 3);

        // Reset after 2 of 4 fragments.
        send_desc(4'd3, 3'd6, 6'h15);
        send_beat(3'd0, 1'b0, '0, 6'h15, 0);
        send_beat(3'd0, 1'b0, '0, 6'h15, 0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_expect_ready", io_expect_ready, 1'b1);
        check("midrst_busy", io_busy, 1'b0);
        check("midrst_in_ready", io_in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_desc(4'd0, 3'd4, 6'h15);
        send_beat(3'd0, 1'b0, 64'h1234, 6'h15, 0);

        // Source mismatch: one-cycle io_error pulse when the check is built in.
        send_desc(4'd0, 3'd6, 6'h15);
        send_beat(3'd0, 1'b0, '0, 6'h16, 0);

        // Randomized requests.
        ready_mode = 0;
        for (int r = 0; r < 40; r++) begin
            send_desc(4'($urandom_range(5)), 3'($urandom_range(7)), 6'($urandom_range(63)));
            for (int b = 0; b <= 5; b++) begin
                logic [2:0] op;
                int k;
                k  = $urandom_range(9);
                op = (k < 6) ? 3'd0 : (k < 9) ? 3'd1 : 3'($urandom_range(7));
                s  = ($urandom_range(9) == 0) ? (m_src ^ 6'h01) : m_src;
                if (m_rem == 0) b = 5;
                send_beat(op, 1'($urandom_range(3) == 0), {$urandom, $urandom}, s, 0);
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_fragment_ack_collector.md
# tl_fragment_ack_collector

D-channel (response-side) companion of the A-channel request repeater used in the fragmenter path. It accepts one fragmentation descriptor per original request, then consumes the downstream per-fragment responses. Data-bearing beats pass through to the initiator with the original source and size restored. Data-less intermediate acks are absorbed, so the initiator sees exactly one AccessAck per original request, and `denied` is accumulated across all fragments.

## Interface
- No parameters; widths fixed: param 2, size 3, source 6, sink 1, data 64.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `io_expect_valid` / `io_expect_ready`  in / out  1  descriptor handshake.
- `io_expect_count`  in  4  number of fragments minus 1.
- `io_expect_size`  in  3  original request size.
- `io_expect_source`  in  6  original request source.
- `io_in_valid` / `io_in_ready`  in / out  1  downstream D beat handshake.
- `io_in_bits_{opcode,param,size,source,sink,denied,data,corrupt}`  in  3/2/3/6/1/1/64/1  downstream D beat.
- `io_out_valid` / `io_out_ready`  out / in  1  upstream D beat handshake.
- `io_out_bits_*`  out  same widths as `io_in_bits_*`  upstream D beat.
- `io_busy`  out  1  collector is in COLLECT.
- `io_error`  out  1  one-cycle pulse on a source mismatch (see Configuration).

## Operation
- States:
  - IDLE: `io_expect_ready`=1, `io_in_ready`=0, `io_out_valid`=0.
  - COLLECT: `io_expect_ready`=0.
- IDLE→COLLECT on expect fire:
  - load `remaining`←`io_expect_count`.
  - load `saved_size`←`io_expect_size` and `saved_source`←`io_expect_source`.
  - clear `denied_acc`.
- A beat fires when `io_in_valid & io_in_ready`. `last` = (`remaining`==0).
- Beat with opcode AccessAck (0) and not `last`: suppressed.
  - `io_in_ready`=1 and `io_out_valid`=0.
  - `denied_acc` |= `io_in_bits_denied`.
- All other beats (AccessAckData=1, any other opcode, or `last`): forwarded combinationally.
  - `io_out_valid`=`io_in_valid`; `io_in_ready`=`io_out_ready`.
  - opcode, param, sink, data and corrupt pass through unchanged.
  - `io_out_bits_size`=`saved_size`; `io_out_bits_source`=`saved_source`.
  - `io_out_bits_denied`=`denied_acc | io_in_bits_denied`.
- Every fired beat decrements `remaining`. Firing the `last` beat returns the block to IDLE.
- `remaining` never wraps: a `last` fire always exits COLLECT.
- Beats are never dropped or reordered. Upstream backpressure stalls only forwarded beats, never suppressed ones.

## Timing
- Forwarded beats have zero latency (combinational in→out). The module has no data storage.
- After the `last` fire, the block spends one IDLE cycle before it can accept the next descriptor. No descriptor fires in the same cycle as a `last` beat.
- A count of 0 means a single beat, which is forwarded as `last`.
- Reset values: state IDLE, `remaining`=0, `denied_acc`=0, `io_busy`=0, `io_error`=0, `io_expect_ready`=1, `io_in_ready`=0, `io_out_valid`=0.
- `io_out_bits_*` are don't-care while `io_out_valid`=0.
- Reset asserted mid-COLLECT: the block immediately returns to IDLE and the partial accumulation is discarded.

## Configuration
- `FRAG_COLLECT_SRC_CHECK_EN` defined:
  - on every fired beat, compare `io_in_bits_source` with `saved_source`.
  - on a mismatch, `io_error` pulses high for the cycle after the fire.
  - the beat is still processed normally.
- Not defined: no comparator; `io_error` is tied to 0.

## Test plan
- Expect (count=3, size=6, source=0x15), then four AccessAck beats from source 0x15 with `io_out_ready`=1 → exactly one output beat (the 4th): opcode 0, size 6, source 0x15. Then IDLE.
- Expect (count=1); both beats are AccessAckData, data 0xA5A5… and 0x5A5A… → two output beats with the same data, size restored, `io_busy` low after the 2nd.
- Expect (count=2); AccessAck beats with denied=0,1,0 → single output with denied=1. The next request with all denied=0 outputs denied=0, confirming the accumulator clears.
- Forwarded beat with `io_out_ready`=0 for 3 cycles → `io_in_ready`=0 for those cycles, and the beat is held and delivered on the first ready cycle. Suppressed beats are consumed despite `io_out_ready`=0.
- Drive `reset` low after 2 of 4 fragments → the block is in IDLE with `io_expect_ready`=1. A fresh count=0 request completes with a single forwarded beat.
- With `FRAG_COLLECT_SRC_CHECK_EN`: a beat with source 0x16 against saved source 0x15 → `io_error` is high for exactly 1 cycle. Without the macro, `io_error` stays 0.
